// File: rtl/ym_bus_sequencer.sv
// rtl/ym_bus_sequencer.sv - queued AY port writes replayed as timed YM2149 BDIR/BC1/DA bus cycles
// Optional register-number skip on repeated address writes: YM_ADDR_SKIP_EN.
module ym_bus_sequencer #(
   parameter int FIFO_DEPTH = 4,
   parameter int SETUP_CYC  = 2,
   parameter int PULSE_CYC  = 3,
   parameter int HOLD_CYC   = 1
) (
   input  logic       cpu_clock,
   input  logic       reset,
   input  logic       req_valid,
   input  logic       req_type,
   input  logic [7:0] req_data,
   output logic       req_ready,
   output logic [7:0] ym_da,
   output logic       ym_da_oe,
   output logic       bc1,
   output logic       bdir,
   output logic       ym_sel,
   output logic       busy
);

   localparam int AW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int MAX_AB  = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
   localparam int MAX_CYC = (MAX_AB > HOLD_CYC) ? MAX_AB : HOLD_CYC;
   localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC + 1) : 1;

   localparam logic [CW-1:0] SETUP_LD = CW'(SETUP_CYC - 1);
   localparam logic [CW-1:0] PULSE_LD = CW'(PULSE_CYC - 1);
   localparam logic [CW-1:0] HOLD_LD  = CW'(HOLD_CYC - 1);
   localparam logic [AW:0]   FULL_CNT = (AW + 1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETUP,
      ST_STROBE,
      ST_HOLD
   } state_t;

   state_t          state_q, state_d;
   logic [8:0]      mem_q [FIFO_DEPTH];
   logic [8:0]      mem_d [FIFO_DEPTH];
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [AW:0]     count_q, count_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [7:0]      ym_da_q, ym_da_d;
   logic            ym_da_oe_q, ym_da_oe_d;
   logic            bc1_q, bc1_d;
   logic            bdir_q, bdir_d;
   logic            ym_sel_q, ym_sel_d;
   logic            kind_addr_q, kind_addr_d;
   logic            push;
   logic            pop;
   logic [8:0]      head;
   logic            head_is_sel;
   logic            addr_skip;

   assign req_ready   = (count_q != FULL_CNT);
   assign busy        = (count_q != '0) || (state_q != ST_IDLE);
   assign ym_da       = ym_da_q;
   assign ym_da_oe    = ym_da_oe_q;
   assign bc1         = bc1_q;
   assign bdir        = bdir_q;
   assign ym_sel      = ym_sel_q;

   assign push        = req_valid && req_ready;
   assign head        = mem_q[rd_ptr_q];
   // 0xFE / 0xFF on the register-select port are TurboSound chip selects, not AY registers
   assign head_is_sel = !head[8] && (head[7:1] == 7'h7F);

`ifdef YM_ADDR_SKIP_EN
   logic [7:0] shadow_q [2];
   logic [7:0] shadow_d [2];
   logic [1:0] shadow_vld_q, shadow_vld_d;

   assign addr_skip = !head[8] && shadow_vld_q[ym_sel_q] && (shadow_q[ym_sel_q] == head[7:0]);

   always_comb begin
      shadow_d     = shadow_q;
      shadow_vld_d = shadow_vld_q;
      if (state_q == ST_SETUP && cnt_q == '0 && kind_addr_q) begin
         shadow_d[ym_sel_q]     = ym_da_q;
         shadow_vld_d[ym_sel_q] = 1'b1;
      end
   end

   always_ff @(posedge cpu_clock or negedge reset) begin
      if (!reset) begin
         shadow_q[0]  <= 8'h00;
         shadow_q[1]  <= 8'h00;
         shadow_vld_q <= 2'b00;
      end else begin
         shadow_q     <= shadow_d;
         shadow_vld_q <= shadow_vld_d;
      end
   end
`else
   assign addr_skip = 1'b0;
`endif

   always_comb begin
      state_d     = state_q;
      mem_d       = mem_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      cnt_d       = cnt_q;
      ym_da_d     = ym_da_q;
      ym_da_oe_d  = ym_da_oe_q;
      bc1_d       = bc1_q;
      bdir_d      = bdir_q;
      ym_sel_d    = ym_sel_q;
      kind_addr_d = kind_addr_q;
      pop         = 1'b0;

      if (push) begin
         mem_d[wr_ptr_q] = {req_type, req_data};
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end

      case (state_q)
         ST_IDLE: begin
            if (count_q != '0) begin
               pop = 1'b1;
               if (head_is_sel) begin
                  ym_sel_d = ~head[0];
               end else if (!addr_skip) begin
                  ym_da_d     = head[7:0];
                  ym_da_oe_d  = 1'b1;
                  kind_addr_d = !head[8];
                  cnt_d       = SETUP_LD;
                  state_d     = ST_SETUP;
               end
            end
         end
         ST_SETUP: begin
            if (cnt_q == '0) begin
               bdir_d  = 1'b1;
               bc1_d   = kind_addr_q;
               cnt_d   = PULSE_LD;
               state_d = ST_STROBE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         ST_STROBE: begin
            if (cnt_q == '0) begin
               bdir_d  = 1'b0;
               bc1_d   = 1'b0;
               cnt_d   = HOLD_LD;
               state_d = ST_HOLD;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         ST_HOLD: begin
            if (cnt_q == '0) begin
               ym_da_oe_d = 1'b0;
               state_d    = ST_IDLE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      if (push && !pop) begin
         count_d = count_q + 1'b1;
      end else if (pop && !push) begin
         count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge cpu_clock or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_q[i] <= 9'h000;
         end
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         cnt_q       <= '0;
         ym_da_q     <= 8'h00;
         ym_da_oe_q  <= 1'b0;
         bc1_q       <= 1'b0;
         bdir_q      <= 1'b0;
         ym_sel_q    <= 1'b0;
         kind_addr_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         mem_q       <= mem_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         cnt_q       <= cnt_d;
         ym_da_q     <= ym_da_d;
         ym_da_oe_q  <= ym_da_oe_d;
         bc1_q       <= bc1_d;
         bdir_q      <= bdir_d;
         ym_sel_q    <= ym_sel_d;
         kind_addr_q <= kind_addr_d;
      end
   end

endmodule
